rv_trace_capture_ctrl: RTL
==========================

Name: rv_trace_capture_ctrl

Overview:
- Synthesizable on-chip trace capture controller for the RV32 core.
- Records retired instructions (PC, opcode, optional timestamp) into a circular buffer.
- Sequences capture: arm, PC-match trigger, post-trigger window, stop.
- Drains the buffer oldest-first through a valid/ready readout port toward the debug/bus side.

Parameters:
- IADDR_SPACE_BITS, 32, instruction address width; PC bit 0 is implicit zero.
- DEPTH_BITS, 4, buffer holds 2**DEPTH_BITS entries.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset; asynchronous, active-low.
- i_retire_valid  in  1  one instruction retires this cycle (write-back stage).
- i_retire_pc  in  IADDR_SPACE_BITS-1:1  PC of the retiring instruction.
- i_retire_instr  in  32  opcode of the retiring instruction.
- i_cfg_arm  in  1  pulse: start capture.
- i_cfg_stop  in  1  pulse: force stop.
- i_trig_en  in  1  enable PC-match trigger.
- i_trig_pc  in  IADDR_SPACE_BITS-1:1  trigger PC.
- i_post_count  in  DEPTH_BITS  entries to record after the trigger entry.
- o_rd_valid  out  1  readout entry available.
- i_rd_ready  in  1  consumer accepts the readout entry.
- o_rd_pc  out  IADDR_SPACE_BITS  readout PC with bit 0 = 0.
- o_rd_instr  out  32  readout opcode.
- o_rd_time  out  32  readout timestamp.
- o_state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- o_count  out  DEPTH_BITS+1  valid entries in the buffer.

Behaviour:
- Reset: state IDLE, wr_ptr=0, count=0, post counter=0, cycle counter=0. All outputs 0; o_rd_valid=0.
- Write rule: in ARMED or POST, when i_retire_valid=1:
  - Store {pc, instr, time} at wr_ptr; wr_ptr++ (mod depth).
  - count = min(count+1, 2**DEPTH_BITS). When full, the oldest entry is overwritten.
- IDLE:
  - i_cfg_arm -> ARMED; clears count and wr_ptr.
  - Retires are ignored.
- ARMED:
  - Records every retire.
  - Trigger = i_trig_en & i_retire_valid & (i_retire_pc == i_trig_pc). The trigger entry is recorded in the same cycle.
  - On trigger: if i_post_count == 0 -> DONE, else load post counter with i_post_count and go to POST.
  - i_cfg_stop -> DONE. Stop has priority over trigger: the retire in that cycle is still recorded, then the state goes to DONE.
  - i_trig_en=0: the block records continuously until stopped.
  - i_cfg_arm while ARMED is ignored.
- POST:
  - Each recorded retire decrements the post counter; the write that brings it to 0 also moves the state to DONE.
  - i_post_count is sampled only at the trigger cycle; later changes have no effect.
  - i_cfg_stop -> DONE.
- DONE:
  - No recording.
  - rd_ptr = wr_ptr - count (mod depth), i.e. the oldest entry first.
  - o_rd_valid = (count != 0); outputs are a combinational read of rd_ptr.
  - On o_rd_valid & i_rd_ready: rd_ptr++, count--.
  - When the last entry pops, go to IDLE in the next cycle.
  - If count = 0 on entry to DONE, return to IDLE the next cycle.
  - i_cfg_arm in DONE aborts the drain: count cleared, state -> ARMED.
  - i_cfg_stop in DONE is ignored.
- Readout handshake:
  - Once o_rd_valid is asserted, outputs stay stable until accepted or until the drain is aborted.
  - Throughput is 1 entry per cycle.
- Pointer arithmetic: all pointers are DEPTH_BITS wide with natural wrap. o_count is never greater than 2**DEPTH_BITS.
- Reset mid-capture or mid-drain: returns immediately to the reset values; buffer contents are not cleared but become unreachable.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter, reset to 0 and wrapping, is stored with each entry.
  - o_rd_time returns the stored counter value.
- Undefined:
  - No counter and no storage for it.
  - o_rd_time is tied to 0.

Decomposition:
- Package rv_trace_pkg holds:
  - enum trace_state_t (IDLE/ARMED/POST/DONE, 2 bits).
  - struct trace_entry_t {pc, instr, and time when TRACE_TIMESTAMP_EN is defined}.
  - Constants for the state encodings used by o_state.
- Sub-module rv_trace_buf: register-array storage with 1 write port and 1 asynchronous read port, parameterised by DEPTH_BITS and entry type.
- The controller holds the FSM, pointers and counters.

Test Plan:
- Continuous capture, DEPTH_BITS=4:
  - Stimulus: arm with i_trig_en=0; retire 20 instructions with PCs 0x100,0x104,…; pulse stop.
  - Required: state DONE, o_count=16, readout gives PCs 0x110…0x14C in order, then state IDLE.
- Trigger with post window:
  - Stimulus: i_trig_pc=0x200, i_post_count=3; retire 0x1F0,0x1F4,0x1F8,0x1FC,0x200,0x204,0x208,0x20C,0x210.
  - Required: DONE after 0x20C; 0x210 not stored; count=8; last 4 entries are 0x200–0x20C.
- Zero post count:
  - Stimulus: i_post_count=0, trigger hits at 0x300.
  - Required: DONE in the next cycle; the last readout entry is 0x300.
- Readout backpressure:
  - Stimulus: toggle i_rd_ready 1,0,0,1.
  - Required: o_rd_pc/o_rd_instr hold stable while ready=0; exactly 2 pops; o_count drops by 2.
- Simultaneous events:
  - Stimulus: stop and trigger asserted in the same cycle as a retire of 0x400, with i_post_count=5.
  - Required: 0x400 recorded, state DONE (not POST).
- Reset mid-drain:
  - Stimulus: deassert i_reset_n during DONE with count=7.
  - Required: o_state=0, o_count=0 and o_rd_valid=0 immediately, without waiting for a clock edge.
  - With TRACE_TIMESTAMP_EN defined: o_rd_time entries differ by the exact retire cycle spacing.

Source files
------------

// File: rtl/rv_trace_pkg.sv
// Shared types and state encodings for the RV32 trace capture controller.
// The entry carries a timestamp field only when TRACE_TIMESTAMP_EN is defined.
package rv_trace_pkg;

    localparam int unsigned TRACE_PC_BITS = 32;

    localparam logic [1:0] TRACE_ST_IDLE  = 2'd0;
    localparam logic [1:0] TRACE_ST_ARMED = 2'd1;
    localparam logic [1:0] TRACE_ST_POST  = 2'd2;
    localparam logic [1:0] TRACE_ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = TRACE_ST_IDLE,
        StArmed = TRACE_ST_ARMED,
        StPost  = TRACE_ST_POST,
        StDone  = TRACE_ST_DONE
    } trace_state_t;

    typedef struct packed {
        logic [TRACE_PC_BITS-1:1] pc;
        logic [31:0]              instr;
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0]              ts;
`endif
    } trace_entry_t;

endpackage

// File: rtl/rv_trace_buf.sv
// Trace entry storage: one synchronous write port and one asynchronous read port.
// Contents are never reset; entry width follows TRACE_TIMESTAMP_EN via trace_entry_t.
module rv_trace_buf
    import rv_trace_pkg::*;
#(
    parameter int unsigned DEPTH_BITS = 4,
    parameter type         entry_t    = trace_entry_t
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_BITS-1:0] i_waddr,
    input  entry_t                i_wdata,
    input  logic [DEPTH_BITS-1:0] i_raddr,
    output entry_t                o_rdata
);

    entry_t mem_q [2**DEPTH_BITS];
    entry_t mem_d [2**DEPTH_BITS];

    always_comb begin
        mem_d = mem_q;
        if (i_we) begin
            mem_d[i_waddr] = i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/rv_trace_capture_ctrl.sv
// Trace capture controller: arm / PC-trigger / post window / drain oldest-first.
// Define TRACE_TIMESTAMP_EN to store a free-running cycle counter with each entry.
module rv_trace_capture_ctrl
    import rv_trace_pkg::*;
#(
    parameter int unsigned IADDR_SPACE_BITS = 32,
    parameter int unsigned DEPTH_BITS       = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_retire_valid,
    input  logic [IADDR_SPACE_BITS-1:1] i_retire_pc,
    input  logic [31:0]                 i_retire_instr,
    input  logic                        i_cfg_arm,
    input  logic                        i_cfg_stop,
    input  logic                        i_trig_en,
    input  logic [IADDR_SPACE_BITS-1:1] i_trig_pc,
    input  logic [DEPTH_BITS-1:0]       i_post_count,
    output logic                        o_rd_valid,
    input  logic                        i_rd_ready,
    output logic [IADDR_SPACE_BITS-1:0] o_rd_pc,
    output logic [31:0]                 o_rd_instr,
    output logic [31:0]                 o_rd_time,
    output logic [1:0]                  o_state,
    output logic [DEPTH_BITS:0]         o_count
);

    localparam logic [DEPTH_BITS:0] COUNT_FULL = {1'b1, {DEPTH_BITS{1'b0}}};

    trace_state_t          state_q, state_d;
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic [DEPTH_BITS-1:0] post_q, post_d;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic                  we;
    logic                  trig;
    logic                  rd_valid;
    trace_entry_t          wdata;
    trace_entry_t          rd_entry;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        post_d   = post_q;
        rd_valid = 1'b0;
        we       = (state_q == StArmed || state_q == StPost) && i_retire_valid;
        trig     = i_trig_en && i_retire_valid && (i_retire_pc == i_trig_pc);

        // Once full, the count saturates and the write overwrites the oldest entry.
        if (we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != COUNT_FULL) begin
                count_d = count_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (i_cfg_arm) begin
                    state_d  = StArmed;
                    count_d  = '0;
                    wr_ptr_d = '0;
                end
            end
            StArmed: begin
                if (i_cfg_stop) begin
                    state_d = StDone;
                end else if (trig) begin
                    if (i_post_count == '0) begin
                        state_d = StDone;
                    end else begin
                        post_d  = i_post_count;
                        state_d = StPost;
                    end
                end
            end
            StPost: begin
                if (i_cfg_stop) begin
                    state_d = StDone;
                end else if (we) begin
                    post_d = post_q - 1'b1;
                    if (post_q == DEPTH_BITS'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                rd_valid = (count_q != '0);
                if (i_cfg_arm) begin
                    state_d = StArmed;
                    count_d = '0;
                end else if (!rd_valid) begin
                    state_d = StIdle;
                end else if (i_rd_ready) begin
                    count_d = count_q - 1'b1;
                    if (count_q == (DEPTH_BITS + 1)'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            post_q   <= post_d;
        end
    end

    // Oldest entry sits count positions behind the write pointer; popping advances it.
    assign rd_ptr = wr_ptr_q - count_q[DEPTH_BITS-1:0];

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] cycle_q, cycle_d;

    assign cycle_d = cycle_q + 32'd1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end
`endif

    always_comb begin
        wdata       = '0;
        wdata.pc    = (TRACE_PC_BITS - 1)'(i_retire_pc);
        wdata.instr = i_retire_instr;
`ifdef TRACE_TIMESTAMP_EN
        wdata.ts    = cycle_q;
`endif
    end

    rv_trace_buf #(
        .DEPTH_BITS (DEPTH_BITS),
        .entry_t    (trace_entry_t)
    ) u_buf (
        .i_clk   (i_clk),
        .i_we    (we),
        .i_waddr (wr_ptr_q),
        .i_wdata (wdata),
        .i_raddr (rd_ptr),
        .o_rdata (rd_entry)
    );

    assign o_rd_valid = rd_valid;
    assign o_rd_pc    = rd_valid ? {rd_entry.pc[IADDR_SPACE_BITS-1:1], 1'b0} : '0;
    assign o_rd_instr = rd_valid ? rd_entry.instr : '0;
`ifdef TRACE_TIMESTAMP_EN
    assign o_rd_time  = rd_valid ? rd_entry.ts : '0;
`else
    assign o_rd_time  = '0;
`endif
    assign o_state    = state_q;
    assign o_count    = count_q;

endmodule
